// File: rtl/pong_input_pkg.sv
// Shared types and timing constants for the push-button conditioning path.
package pong_input_pkg;

   // Per-channel auto-repeat state
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   // Default timings for a 25 MHz clock
   localparam int DEBOUNCE_10MS_25MHZ = 250000;
   localparam int REPEAT_DELAY_200MS  = 5000000;
   localparam int REPEAT_PERIOD_50MS  = 1250000;

   // Counter width able to hold max(a,b)-1, never narrower than one bit
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/key_channel.sv
// One button: two-flop synchronizer, debounce filter, press/release strobes
// and the auto-repeat move strobe. All outputs come straight from flops.
module key_channel
   import pong_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_200MS,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_50MS
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_move
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES, 1);
   localparam int RW = cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RDLY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RPER_LAST = RW'(REPEAT_PERIOD - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          stable_q, stable_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   state_t        state_q, state_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          move_q, move_d;
   logic          press_s, release_s;

   // Synchronizer shift and debounce: accept a change after DEBOUNCE_CYCLES mismatching samples
   always_comb begin
      sync1_d   = key_n;
      sync2_d   = sync1_q;
      stable_d  = stable_q;
      dcnt_d    = dcnt_q;
      press_s   = 1'b0;
      release_s = 1'b0;
      if (sync2_q == stable_q) begin
         dcnt_d = '0;
      end else if (dcnt_q == DCNT_LAST) begin
         stable_d  = ~stable_q;
         dcnt_d    = '0;
         // stable is active-low: leaving 1 means the button went down
         press_s   = stable_q;
         release_s = ~stable_q;
      end else begin
         dcnt_d = dcnt_q + DW'(1'b1);
      end
      level_d   = ~stable_d;
      press_d   = press_s;
      release_d = release_s;
   end

   // Auto-repeat FSM: move on press, after REPEAT_DELAY, then every REPEAT_PERIOD; release wins
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      move_d  = 1'b0;
      case (state_q)
         IDLE: begin
            rcnt_d = '0;
            if (press_s) begin
               move_d  = 1'b1;
               state_d = DELAY;
            end else begin
               state_d = IDLE;
            end
         end
         DELAY: begin
            if (release_s) begin
               rcnt_d  = '0;
               state_d = IDLE;
            end else if (rcnt_q == RDLY_LAST) begin
               move_d  = 1'b1;
               rcnt_d  = '0;
               state_d = REPEAT;
            end else begin
               rcnt_d = rcnt_q + RW'(1'b1);
            end
         end
         REPEAT: begin
            if (release_s) begin
               rcnt_d  = '0;
               state_d = IDLE;
            end else if (rcnt_q == RPER_LAST) begin
               move_d = 1'b1;
               rcnt_d = '0;
            end else begin
               rcnt_d = rcnt_q + RW'(1'b1);
            end
         end
         default: begin
            rcnt_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset leaves the button reading as released
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         stable_q  <= 1'b1;
         dcnt_q    <= '0;
         state_q   <= IDLE;
         rcnt_q    <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         move_q    <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         stable_q  <= stable_d;
         dcnt_q    <= dcnt_d;
         state_q   <= state_d;
         rcnt_q    <= rcnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         move_q    <= move_d;
      end
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_move    = move_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions all board buttons in parallel; each bit is an independent key_channel.
module key_conditioner
   import pong_input_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_200MS,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_50MS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_n,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_move
);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .key_n      (key_n[i]),
         .key_level  (key_level[i]),
         .key_press  (key_press[i]),
         .key_release(key_release[i]),
         .key_move   (key_move[i])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: behavioural model compared every cycle, plus directed literal checks.
module tb_key_conditioner;

   localparam int NK = 4;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [NK-1:0] key_n;
   logic [NK-1:0] key_level, key_press, key_release, key_move;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   key_conditioner #(
      .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .reset(reset), .key_n(key_n),
      .key_level(key_level), .key_press(key_press),
      .key_release(key_release), .key_move(key_move)
   );

   // ---------------- behavioural model ----------------
   // samp[k][i]: key_n[k] as sampled i edges ago (i=0 newest). The filter sees the
   // value sampled two edges back; a change is accepted once the last DB values
   // it has seen all differ from the accepted state.
   bit            samp [NK][DB+2];
   bit            m_stable [NK];
   int            m_ptime [NK];
   int            cyc = 0;
   logic [NK-1:0] e_level = '0, e_press = '0, e_release = '0, e_move = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc = 0;
         for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < DB + 2; i++) samp[k][i] = 1'b1;
            m_stable[k] = 1'b1;
            m_ptime[k]  = 0;
         end
         e_level = '0; e_press = '0; e_release = '0; e_move = '0;
      end else begin
         cyc = cyc + 1;
         for (int k = 0; k < NK; k++) begin
            bit all_diff;
            int d;
            for (int i = DB + 1; i > 0; i--) samp[k][i] = samp[k][i-1];
            samp[k][0] = key_n[k];
            all_diff = 1'b1;
            for (int i = 2; i <= DB + 1; i++)
               if (samp[k][i] == m_stable[k]) all_diff = 1'b0;
            e_press[k] = 1'b0; e_release[k] = 1'b0; e_move[k] = 1'b0;
            if (all_diff) begin
               m_stable[k] = ~m_stable[k];
               if (!m_stable[k]) begin
                  e_press[k] = 1'b1;
                  e_move[k]  = 1'b1;
                  m_ptime[k] = cyc;
               end else begin
                  e_release[k] = 1'b1;
               end
            end else if (!m_stable[k]) begin
               d = cyc - m_ptime[k];
               if (d >= RD && ((d - RD) % RP) == 0) e_move[k] = 1'b1;
            end
            e_level[k] = ~m_stable[k];
         end
      end
   end

   // Per-cycle comparison of every output against the model, plus press/release exclusivity
   always @(negedge clk) begin
      n_tests++;
      if ({key_level, key_press, key_release, key_move} !== {e_level, e_press, e_release, e_move}) begin
         n_fail++;
         $display("FAIL model_cmp t=%0t got lvl=%b pr=%b rl=%b mv=%b expected lvl=%b pr=%b rl=%b mv=%b",
                  $time, key_level, key_press, key_release, key_move,
                  e_level, e_press, e_release, e_move);
      end
      n_tests++;
      if ((key_press & key_release) !== '0) begin
         n_fail++;
         $display("FAIL press_release_excl t=%0t got %b expected 0", $time, key_press & key_release);
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      logic [63:0] mask, exp_mask;
      int pos [11] = '{0, 10, 13, 16, 19, 22, 25, 28, 31, 34, 37};
      int rel_at, n_rel, n_mv, seen;
      int hold [NK];

      reset = 1'b1;
      key_n = '1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_level",   key_level,   0);
      chk("reset_press",   key_press,   0);
      chk("reset_release", key_release, 0);
      chk("reset_move",    key_move,    0);
      @(negedge clk);
      reset = 1'b0;

      // Clean press on key 0: high after edge 5 counting the first low sample as edge 0
      @(negedge clk); key_n[0] = 1'b0;
      @(posedge clk);
      step(4);
      chk("press0_early_level", key_level[0], 0);
      chk("model_press0_early", e_level[0], 0);
      step(1);
      chk("press0_level", key_level[0], 1);
      chk("press0_press", key_press[0], 1);
      chk("press0_move",  key_move[0],  1);
      chk("model_press0", e_press[0],   1);
      step(1);
      chk("press0_press_1cyc", key_press[0], 0);
      chk("press0_move_1cyc",  key_move[0],  0);
      chk("press0_level_hold", key_level[0], 1);
      @(negedge clk); key_n[0] = 1'b1;
      repeat (10) @(negedge clk);

      // Bounce on key 1: low 3, high 1, low 3, high
      seen = 0;
      for (int i = 0; i < 16; i++) begin
         key_n[1] = (i == 3 || i >= 7) ? 1'b1 : 1'b0;
         @(negedge clk);
         seen = seen | int'(key_level[1] | key_press[1] | key_move[1] | key_release[1]);
      end
      chk("bounce_no_change", seen, 0);
      key_n[1] = 1'b0;
      @(posedge clk);
      step(4);
      chk("bounce_hold_early", key_level[1], 0);
      step(1);
      chk("bounce_hold_press", key_press[1], 1);

      // Auto-repeat on key 2 across 40 cycles from the press strobe
      @(negedge clk); key_n[2] = 1'b0;
      @(posedge clk);
      step(5);
      chk("repeat_press", key_press[2], 1);
      mask = '0;
      exp_mask = '0;
      for (int i = 0; i < 11; i++) exp_mask[pos[i]] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) step(1);
         mask[i] = key_move[2];
      end
      chk("repeat_mask", mask, exp_mask);
      @(negedge clk); key_n[2] = 1'b1; key_n[1] = 1'b1;
      repeat (12) @(negedge clk);

      // Release during DELAY on key 1: release toggle coincides with the delay terminal count
      @(negedge clk); key_n[1] = 1'b0;
      @(posedge clk);
      step(5);
      chk("delay_rel_press", key_press[1], 1);
      step(4);
      @(negedge clk); key_n[1] = 1'b1;
      n_mv = 0; n_rel = 0; rel_at = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (key_move[1]) n_mv++;
         if (key_release[1]) begin n_rel++; rel_at = i; end
      end
      chk("delay_rel_pos",   rel_at, 6);
      chk("delay_rel_count", n_rel,  1);
      chk("delay_rel_moves", n_mv,   0);

      // Simultaneous keys 0 and 3, then release key 3 only
      @(negedge clk); key_n[0] = 1'b0; key_n[3] = 1'b0;
      @(posedge clk);
      step(5);
      chk("simul_press", key_press, 4'b1001);
      chk("simul_level", key_level, 4'b1001);
      step(3);
      @(negedge clk); key_n[3] = 1'b1;
      @(posedge clk);
      step(5);
      chk("simul_release",   key_release, 4'b1000);
      chk("simul_level_rel", key_level,   4'b0001);

      // Reset while key 0 is auto-repeating; still held afterwards
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_level",   key_level,   0);
      chk("midrst_press",   key_press,   0);
      chk("midrst_release", key_release, 0);
      chk("midrst_move",    key_move,    0);
      chk("model_midrst",   e_level,     0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk);
      step(4);
      chk("midrst_early", key_level[0], 0);
      step(1);
      chk("midrst_repress", key_press[0], 1);
      @(negedge clk); key_n = '1;
      repeat (10) @(negedge clk);

      // Random phase, checked by the per-cycle model comparison
      for (int k = 0; k < NK; k++) hold[k] = 0;
      repeat (3000) begin
         @(negedge clk);
         if ($urandom_range(0, 599) == 0) begin
            #2 reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
         for (int k = 0; k < NK; k++) begin
            if (hold[k] == 0) begin
               key_n[k] = 1'($urandom_range(0, 1));
               hold[k]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                                      : int'($urandom_range(1, 6));
            end else begin
               hold[k] = hold[k] - 1;
            end
         end
      end
      key_n = '1;
      repeat (20) @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
